// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported main memory between IC line fills and
// DC fills/stores. One transaction in flight; DRAIN after reset swallows stale read responses.
module mem_arbiter #(
  parameter int ADDRESS_WIDTH      = 32,
  parameter int FILL_DATA_WIDTH    = 128,
  parameter int EVICT_DATA_WIDTH   = 32,
  parameter int DATA_TRANSFER_TIME = 5,
  parameter int TIMEOUT            = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ic_req,
  input  logic [ADDRESS_WIDTH-1:0]    ic_address,
  output logic [FILL_DATA_WIDTH-1:0]  ic_fill_data,
  output logic                        ic_valid,
  input  logic                        dc_req,
  input  logic                        dc_store,
  input  logic                        dc_store_word,
  input  logic [ADDRESS_WIDTH-1:0]    dc_address,
  input  logic [EVICT_DATA_WIDTH-1:0] dc_evict_data,
  output logic [FILL_DATA_WIDTH-1:0]  dc_fill_data,
  output logic                        dc_valid,
  output logic                        mem_req,
  output logic                        mem_store,
  output logic                        mem_store_word,
  output logic [ADDRESS_WIDTH-1:0]    mem_address,
  output logic [EVICT_DATA_WIDTH-1:0] mem_evict_data,
  input  logic [FILL_DATA_WIDTH-1:0]  mem_fill_data,
  input  logic                        mem_response_valid,
  output logic                        err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DATA_TRANSFER_TIME - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_DRAIN = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic G_IC = 1'b0;
  localparam logic G_DC = 1'b1;

  logic [2:0]                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        last_grant_q, last_grant_d;
  logic                        grant_q, grant_d;
  logic                        mem_store_q, mem_store_d;
  logic                        mem_store_word_q, mem_store_word_d;
  logic [ADDRESS_WIDTH-1:0]    mem_address_q, mem_address_d;
  logic [EVICT_DATA_WIDTH-1:0] mem_evict_data_q, mem_evict_data_d;
  logic [FILL_DATA_WIDTH-1:0]  ic_fill_q, ic_fill_d;
  logic [FILL_DATA_WIDTH-1:0]  dc_fill_q, dc_fill_d;
  logic                        err_q, err_d;
  logic                        grant_sel;

  // With both requesting, the one not served last wins; otherwise whoever asks.
  assign grant_sel = (ic_req && dc_req) ? ~last_grant_q : dc_req;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    last_grant_d     = last_grant_q;
    grant_d          = grant_q;
    mem_store_d      = mem_store_q;
    mem_store_word_d = mem_store_word_q;
    mem_address_d    = mem_address_q;
    mem_evict_data_d = mem_evict_data_q;
    ic_fill_d        = ic_fill_q;
    dc_fill_d        = dc_fill_q;
    err_d            = err_q;
    case (state_q)
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (ic_req || dc_req) begin
          grant_d      = grant_sel;
          last_grant_d = grant_sel;
          state_d      = S_ISSUE;
          if (grant_sel == G_DC) begin
            mem_store_d      = dc_store;
            mem_store_word_d = dc_store_word;
            mem_address_d    = dc_address;
            mem_evict_data_d = dc_evict_data;
          end else begin
            mem_store_d      = 1'b0;
            mem_store_word_d = 1'b0;
            mem_address_d    = ic_address;
            mem_evict_data_d = '0;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = mem_store_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (mem_response_valid) begin
          state_d = S_RESP;
          if (grant_q == G_DC) dc_fill_d = mem_fill_data;
          else                 ic_fill_d = mem_fill_data;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          if (grant_q == G_DC) dc_fill_d = '0;
          else                 ic_fill_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_DRAIN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_DRAIN;
      cnt_q            <= '0;
      last_grant_q     <= G_IC;
      grant_q          <= G_IC;
      mem_store_q      <= 1'b0;
      mem_store_word_q <= 1'b0;
      mem_address_q    <= '0;
      mem_evict_data_q <= '0;
      ic_fill_q        <= '0;
      dc_fill_q        <= '0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      last_grant_q     <= last_grant_d;
      grant_q          <= grant_d;
      mem_store_q      <= mem_store_d;
      mem_store_word_q <= mem_store_word_d;
      mem_address_q    <= mem_address_d;
      mem_evict_data_q <= mem_evict_data_d;
      ic_fill_q        <= ic_fill_d;
      dc_fill_q        <= dc_fill_d;
      err_q            <= err_d;
    end
  end

  assign mem_req        = (state_q == S_ISSUE);
  assign ic_valid       = (state_q == S_RESP) && (grant_q == G_IC);
  assign dc_valid       = (state_q == S_RESP) && (grant_q == G_DC);
  assign mem_store      = mem_store_q;
  assign mem_store_word = mem_store_word_q;
  assign mem_address    = mem_address_q;
  assign mem_evict_data = mem_evict_data_q;
  assign ic_fill_data   = ic_fill_q;
  assign dc_fill_data   = dc_fill_q;
  assign err_timeout    = err_q;

endmodule
